// File: rtl/demux1to5_buf.sv
// rtl/demux1to5_buf.sv - registered 1-to-5 valid/ready stream demultiplexer
module demux1to5_buf #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [2:0]            control_signal_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] demux_o,
    output logic [4:0]            valid_o,
    input  logic [4:0]            ready_i,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state_q, state_d;
    logic [2:0]            dest_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic sel_ready;
    logic drain;
    logic accept;
    logic legal;
    logic load;

    // Only the port currently addressed by dest_q may release the buffer.
    always_comb begin
        sel_ready = 1'b0;
        case (dest_q)
            3'd0:    sel_ready = ready_i[0];
            3'd1:    sel_ready = ready_i[1];
            3'd2:    sel_ready = ready_i[2];
            3'd3:    sel_ready = ready_i[3];
            3'd4:    sel_ready = ready_i[4];
            default: sel_ready = 1'b0;
        endcase
    end

    assign drain   = (state_q == FULL) & sel_ready;
    assign ready_o = (state_q == EMPTY) | drain;
    assign accept  = valid_i & ready_o;
    assign legal   = (control_signal_i <= 3'd4);
    assign load    = accept & legal;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = FULL;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dest_q <= 3'd0;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (load) begin
                dest_q <= control_signal_i;
                data_q <= data_i;
            end
            // Illegal beats are swallowed; the counter sticks at all-ones.
            if (accept && !legal) begin
                err_q <= 1'b1;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign valid_o    = (state_q == FULL) ? (5'b00001 << dest_q) : 5'b00000;
    assign demux_o    = data_q;
    assign err_o      = err_q;
    assign drop_cnt_o = cnt_q;

endmodule
